// File: rtl/credit_fifo_link_if.sv
// Request/response handshake bundle for credit_fifo_link.
// The slave modport is the link itself; master is the core-side driver.
interface credit_fifo_link_if #(
  parameter int W  = 40,
  parameter int CW = 6
);
  logic [W-1:0]  mc_sreq_inbits;
  logic          mc_sreq_wen;
  logic          mc_sreq_fifo_empty;
  logic          mc_sreq_fifo_full;
  logic          sc_rreq_ren;
  logic [W-1:0]  sc_rreq_outbits;
  logic          sc_rreq_fifo_empty;
  logic [W-1:0]  sc_sresp_inbits;
  logic          sc_sresp_wen;
  logic          sc_sresp_fifo_empty;
  logic          sc_sresp_fifo_full;
  logic          mc_rresp_ren;
  logic [W-1:0]  mc_rresp_outbits;
  logic          mc_rresp_fifo_empty;
  logic [CW-1:0] credits_m2s;
  logic [CW-1:0] credits_s2m;
  logic [3:0]    error;

  modport master (
    output mc_sreq_inbits, mc_sreq_wen, sc_rreq_ren,
    output sc_sresp_inbits, sc_sresp_wen, mc_rresp_ren,
    input  mc_sreq_fifo_empty, mc_sreq_fifo_full,
    input  sc_rreq_outbits, sc_rreq_fifo_empty,
    input  sc_sresp_fifo_empty, sc_sresp_fifo_full,
    input  mc_rresp_outbits, mc_rresp_fifo_empty,
    input  credits_m2s, credits_s2m, error
  );

  modport slave (
    input  mc_sreq_inbits, mc_sreq_wen, sc_rreq_ren,
    input  sc_sresp_inbits, sc_sresp_wen, mc_rresp_ren,
    output mc_sreq_fifo_empty, mc_sreq_fifo_full,
    output sc_rreq_outbits, sc_rreq_fifo_empty,
    output sc_sresp_fifo_empty, sc_sresp_fifo_full,
    output mc_rresp_outbits, mc_rresp_fifo_empty,
    output credits_m2s, credits_s2m, error
  );
endinterface

// File: rtl/credit_fifo_link.sv
// Two independent credit-flow channels: send FIFO -> credit gate ->
// receive FIFO, with a delayed credit-return shift register.
module credit_dir #(
  parameter int FIFO_DEPTH   = 32,
  parameter int LOG2_DEPTH   = 5,
  parameter int W            = 40,
  parameter int CREDIT_DELAY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [W-1:0]      inbits,
  input  logic              wen,
  output logic              send_empty,
  output logic              send_full,
  input  logic              ren,
  output logic [W-1:0]      outbits,
  output logic              recv_empty,
  output logic [LOG2_DEPTH:0] credits,
  output logic [1:0]        err
);
  localparam int CW = LOG2_DEPTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [W-1:0] smem [FIFO_DEPTH];
  logic [W-1:0] rmem [FIFO_DEPTH];
  logic [LOG2_DEPTH-1:0] swp, srp, rwp, rrp;
  logic [CW-1:0] scnt, rcnt, cred;
  logic [CREDIT_DELAY-1:0] pipe;
  logic wr, xfer, rd, ret;

  assign wr   = wen && (scnt != DEPTH_C);
  assign xfer = (scnt != '0) && (cred != '0);
  assign rd   = ren && (rcnt != '0);
  assign ret  = pipe[CREDIT_DELAY-1];

  always_ff @(posedge clk) begin
    if (wr)   smem[swp] <= inbits;
    if (xfer) rmem[rwp] <= smem[srp];
  end

  // credits only ever move by +ret -xfer, so they net out on a shared edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      swp  <= '0;
      srp  <= '0;
      rwp  <= '0;
      rrp  <= '0;
      scnt <= '0;
      rcnt <= '0;
      cred <= DEPTH_C;
      pipe <= '0;
      err  <= '0;
    end else begin
      if (wr)   swp <= swp + 1'b1;
      if (xfer) srp <= srp + 1'b1;
      if (xfer) rwp <= rwp + 1'b1;
      if (rd)   rrp <= rrp + 1'b1;
      scnt <= scnt + CW'(wr) - CW'(xfer);
      rcnt <= rcnt + CW'(xfer) - CW'(rd);
      cred <= cred + CW'(ret) - CW'(xfer);
      pipe <= CREDIT_DELAY'({pipe, rd});
      err  <= err | {ren && (rcnt == '0),
                     wen && (scnt == DEPTH_C)};
    end
  end

  assign send_empty = (scnt == '0);
  assign send_full  = (scnt == DEPTH_C);
  assign recv_empty = (rcnt == '0);
  assign outbits    = recv_empty ? '0 : rmem[rrp];
  assign credits    = cred;
endmodule

module credit_fifo_link #(
  parameter int FIFO_DEPTH         = 32,
  parameter int LOG2_FIFO_DEPTH    = 5,
  parameter int DATA_LINE_WIDTH    = 40,
  parameter int CONTROL_LINE_WIDTH = 0,
  parameter int CREDIT_DELAY       = 1
) (
  input logic clk,
  input logic rst,
  credit_fifo_link_if.slave link
);
  localparam int W = DATA_LINE_WIDTH + CONTROL_LINE_WIDTH;

  logic [1:0] err_req, err_resp;

  credit_dir #(
    .FIFO_DEPTH  (FIFO_DEPTH),
    .LOG2_DEPTH  (LOG2_FIFO_DEPTH),
    .W           (W),
    .CREDIT_DELAY(CREDIT_DELAY)
  ) u_req (
    .clk       (clk),
    .rst       (rst),
    .inbits    (link.mc_sreq_inbits),
    .wen       (link.mc_sreq_wen),
    .send_empty(link.mc_sreq_fifo_empty),
    .send_full (link.mc_sreq_fifo_full),
    .ren       (link.sc_rreq_ren),
    .outbits   (link.sc_rreq_outbits),
    .recv_empty(link.sc_rreq_fifo_empty),
    .credits   (link.credits_m2s),
    .err       (err_req)
  );

  credit_dir #(
    .FIFO_DEPTH  (FIFO_DEPTH),
    .LOG2_DEPTH  (LOG2_FIFO_DEPTH),
    .W           (W),
    .CREDIT_DELAY(CREDIT_DELAY)
  ) u_resp (
    .clk       (clk),
    .rst       (rst),
    .inbits    (link.sc_sresp_inbits),
    .wen       (link.sc_sresp_wen),
    .send_empty(link.sc_sresp_fifo_empty),
    .send_full (link.sc_sresp_fifo_full),
    .ren       (link.mc_rresp_ren),
    .outbits   (link.mc_rresp_outbits),
    .recv_empty(link.mc_rresp_fifo_empty),
    .credits   (link.credits_s2m),
    .err       (err_resp)
  );

  assign link.error = {err_resp, err_req};
endmodule

// File: tb/tb_credit_fifo_link.sv
// Directed bench for credit_fifo_link (depth 32, 40-bit words,
// credit delay 3).
module tb_credit_fifo_link;
  localparam int W  = 40;
  localparam int CW = 6;

  logic clk = 0;
  logic rst = 0;
  int total = 0;
  int bad   = 0;

  credit_fifo_link_if #(.W(W), .CW(CW)) ifc ();

  credit_fifo_link #(
    .FIFO_DEPTH        (32),
    .LOG2_FIFO_DEPTH   (5),
    .DATA_LINE_WIDTH   (40),
    .CONTROL_LINE_WIDTH(0),
    .CREDIT_DELAY      (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .link(ifc.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ifc.mc_sreq_inbits  = '0;
    ifc.mc_sreq_wen     = 0;
    ifc.sc_rreq_ren     = 0;
    ifc.sc_sresp_inbits = '0;
    ifc.sc_sresp_wen    = 0;
    ifc.mc_rresp_ren    = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    #3;
    rst = 0;
    step();
  endtask

  task automatic test_reset();
    idle_inputs();
    #2 rst = 1;
    #1;
    total++;
    if (ifc.credits_m2s !== 6'd32) begin
      bad++; $display("FAIL rst_cred_m2s got=%0d exp=32", ifc.credits_m2s);
    end
    total++;
    if (ifc.credits_s2m !== 6'd32) begin
      bad++; $display("FAIL rst_cred_s2m got=%0d exp=32", ifc.credits_s2m);
    end
    total++;
    if ({ifc.mc_sreq_fifo_empty, ifc.mc_sreq_fifo_full,
         ifc.sc_rreq_fifo_empty, ifc.sc_sresp_fifo_empty,
         ifc.sc_sresp_fifo_full, ifc.mc_rresp_fifo_empty} !== 6'b101101) begin
      bad++; $display("FAIL rst_flags got=%b%b%b%b%b%b exp=101101",
        ifc.mc_sreq_fifo_empty, ifc.mc_sreq_fifo_full,
        ifc.sc_rreq_fifo_empty, ifc.sc_sresp_fifo_empty,
        ifc.sc_sresp_fifo_full, ifc.mc_rresp_fifo_empty);
    end
    total++;
    if (ifc.sc_rreq_outbits !== '0 || ifc.mc_rresp_outbits !== '0) begin
      bad++; $display("FAIL rst_outbits got=%h/%h exp=0",
        ifc.sc_rreq_outbits, ifc.mc_rresp_outbits);
    end
    total++;
    if (ifc.error !== 4'b0000) begin
      bad++; $display("FAIL rst_error got=%b exp=0000", ifc.error);
    end
    step();
    rst = 0;
  endtask

  task automatic test_single();
    ifc.mc_sreq_inbits = 40'h12_3456_789A;
    ifc.mc_sreq_wen    = 1;
    step();
    ifc.mc_sreq_wen = 0;
    total++;
    if (ifc.mc_sreq_fifo_empty !== 1'b0 || ifc.sc_rreq_fifo_empty !== 1'b1) begin
      bad++; $display("FAIL single_e0 got=%b%b exp=01",
        ifc.mc_sreq_fifo_empty, ifc.sc_rreq_fifo_empty);
    end
    step();
    total++;
    if (ifc.sc_rreq_fifo_empty !== 1'b0 ||
        ifc.sc_rreq_outbits !== 40'h12_3456_789A) begin
      bad++; $display("FAIL single_data got=%b/%h exp=0/123456789a",
        ifc.sc_rreq_fifo_empty, ifc.sc_rreq_outbits);
    end
    total++;
    if (ifc.credits_m2s !== 6'd31) begin
      bad++; $display("FAIL single_cred got=%0d exp=31", ifc.credits_m2s);
    end
    ifc.sc_rreq_ren = 1;
    step();
    ifc.sc_rreq_ren = 0;
    total++;
    if (ifc.sc_rreq_fifo_empty !== 1'b1 || ifc.sc_rreq_outbits !== '0) begin
      bad++; $display("FAIL single_pop got=%b/%h exp=1/0",
        ifc.sc_rreq_fifo_empty, ifc.sc_rreq_outbits);
    end
    for (int d = 1; d <= 3; d++) begin
      step();
      total++;
      if (ifc.credits_m2s !== ((d == 3) ? 6'd32 : 6'd31)) begin
        bad++; $display("FAIL single_ret d=%0d got=%0d exp=%0d",
          d, ifc.credits_m2s, (d == 3) ? 32 : 31);
      end
    end
  endtask

  task automatic test_exhaust();
    for (int i = 0; i < 40; i++) begin
      ifc.mc_sreq_inbits = 40'h100 + 40'(i);
      ifc.mc_sreq_wen    = 1;
      step();
      if (i == 31 || i == 32) begin
        total++;
        if (ifc.credits_m2s !== ((i == 31) ? 6'd1 : 6'd0)) begin
          bad++; $display("FAIL exh_cred i=%0d got=%0d exp=%0d",
            i, ifc.credits_m2s, (i == 31) ? 1 : 0);
        end
      end
    end
    ifc.mc_sreq_wen = 0;
    step();
    step();
    total++;
    if (ifc.credits_m2s !== 6'd0 || ifc.mc_sreq_fifo_full !== 1'b0 ||
        ifc.mc_sreq_fifo_empty !== 1'b0) begin
      bad++; $display("FAIL exh_hold got=%0d/%b/%b exp=0/0/0",
        ifc.credits_m2s, ifc.mc_sreq_fifo_full, ifc.mc_sreq_fifo_empty);
    end
    total++;
    if (ifc.sc_rreq_outbits !== 40'h100) begin
      bad++; $display("FAIL exh_head got=%h exp=100", ifc.sc_rreq_outbits);
    end
  endtask

  task automatic test_credit_return();
    ifc.sc_rreq_ren = 1;
    step();
    ifc.sc_rreq_ren = 0;
    total++;
    if (ifc.sc_rreq_outbits !== 40'h101) begin
      bad++; $display("FAIL cr_head got=%h exp=101", ifc.sc_rreq_outbits);
    end
    for (int d = 1; d <= 4; d++) begin
      if (d > 1) step();
      total++;
      if (ifc.credits_m2s !== 6'd0) begin
        bad++; $display("FAIL cr_wait d=%0d got=%0d exp=0", d, ifc.credits_m2s);
      end
      if (d == 3) break;
    end
    step();
    total++;
    if (ifc.credits_m2s !== 6'd1) begin
      bad++; $display("FAIL cr_ret got=%0d exp=1", ifc.credits_m2s);
    end
    step();
    total++;
    if (ifc.credits_m2s !== 6'd0) begin
      bad++; $display("FAIL cr_xfer got=%0d exp=0", ifc.credits_m2s);
    end
  endtask

  task automatic test_back_to_back();
    int xq, rq, xs, rs;
    do_reset();
    for (int k = 0; k <= 25; k++) begin
      ifc.mc_sreq_wen     = (k < 20);
      ifc.mc_sreq_inbits  = 40'hA0_0000_0000 + 40'(k);
      ifc.sc_rreq_ren     = (k >= 2 && k <= 21);
      ifc.sc_sresp_wen    = (k % 2 == 0) && (k <= 18);
      ifc.sc_sresp_inbits = 40'h50_0000_0000 + 40'(k / 2);
      ifc.mc_rresp_ren    = (k % 2 == 0) && (k >= 2) && (k <= 20);
      step();
      xq = (k < 20) ? k : 20;
      rq = (k < 5) ? 0 : ((k - 4 < 20) ? k - 4 : 20);
      xs = 0;
      rs = 0;
      for (int j = 1; j <= k; j++) begin
        if (j % 2 == 1 && j <= 19) xs++;
        if (j % 2 == 1 && j >= 5 && j <= 23) rs++;
      end
      total++;
      if (ifc.credits_m2s !== 6'(32 - xq + rq)) begin
        bad++; $display("FAIL b2b_cred_m2s k=%0d got=%0d exp=%0d",
          k, ifc.credits_m2s, 32 - xq + rq);
      end
      total++;
      if (ifc.credits_s2m !== 6'(32 - xs + rs)) begin
        bad++; $display("FAIL b2b_cred_s2m k=%0d got=%0d exp=%0d",
          k, ifc.credits_s2m, 32 - xs + rs);
      end
      if (k >= 1 && k <= 20) begin
        total++;
        if (ifc.sc_rreq_outbits !== 40'hA0_0000_0000 + 40'(k - 1)) begin
          bad++; $display("FAIL b2b_req_data k=%0d got=%h", k, ifc.sc_rreq_outbits);
        end
      end
      if (k % 2 == 1 && k <= 19) begin
        total++;
        if (ifc.mc_rresp_outbits !== 40'h50_0000_0000 + 40'((k - 1) / 2)) begin
          bad++; $display("FAIL b2b_resp_data k=%0d got=%h", k, ifc.mc_rresp_outbits);
        end
      end
      if (k % 2 == 0 && k >= 2 && k <= 20) begin
        total++;
        if (ifc.mc_rresp_fifo_empty !== 1'b1) begin
          bad++; $display("FAIL b2b_resp_empty k=%0d got=%b exp=1",
            k, ifc.mc_rresp_fifo_empty);
        end
      end
    end
    idle_inputs();
    total++;
    if (ifc.error !== 4'b0000) begin
      bad++; $display("FAIL b2b_error got=%b exp=0000", ifc.error);
    end
  endtask

  task automatic test_errors();
    do_reset();
    ifc.sc_rreq_ren = 1;
    step();
    ifc.sc_rreq_ren = 0;
    total++;
    if (ifc.error !== 4'b0010) begin
      bad++; $display("FAIL err_rd got=%b exp=0010", ifc.error);
    end
    for (int k = 0; k <= 64; k++) begin
      ifc.mc_sreq_inbits = 40'(k);
      ifc.mc_sreq_wen    = 1;
      step();
      if (k == 63) begin
        total++;
        if (ifc.mc_sreq_fifo_full !== 1'b1 || ifc.error !== 4'b0010) begin
          bad++; $display("FAIL err_full got=%b/%b exp=1/0010",
            ifc.mc_sreq_fifo_full, ifc.error);
        end
      end
    end
    ifc.mc_sreq_wen = 0;
    total++;
    if (ifc.error !== 4'b0011) begin
      bad++; $display("FAIL err_wr got=%b exp=0011", ifc.error);
    end
    for (int c = 0; c < 10; c++) begin
      step();
      total++;
      if (ifc.error !== 4'b0011) begin
        bad++; $display("FAIL err_sticky c=%0d got=%b exp=0011", c, ifc.error);
      end
    end
    ifc.mc_sreq_wen = 1;
    #2 rst = 1;
    #1;
    total++;
    if (ifc.error !== 4'b0000 || ifc.credits_m2s !== 6'd32 ||
        ifc.credits_s2m !== 6'd32) begin
      bad++; $display("FAIL mid_rst_state got=%b/%0d/%0d exp=0000/32/32",
        ifc.error, ifc.credits_m2s, ifc.credits_s2m);
    end
    total++;
    if (ifc.mc_sreq_fifo_empty !== 1'b1 || ifc.mc_sreq_fifo_full !== 1'b0 ||
        ifc.sc_rreq_fifo_empty !== 1'b1 || ifc.sc_rreq_outbits !== '0) begin
      bad++; $display("FAIL mid_rst_q got=%b%b%b/%h exp=101/0",
        ifc.mc_sreq_fifo_empty, ifc.mc_sreq_fifo_full,
        ifc.sc_rreq_fifo_empty, ifc.sc_rreq_outbits);
    end
    idle_inputs();
    step();
    rst = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_exhaust();
    test_credit_return();
    test_back_to_back();
    test_errors();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
